ascon_hash_ctrl: RTL and testbench
==================================

ASCON_HASH_CTRL -- requirements
Module: ascon_hash_ctrl

Interface
REQ-001 SHALL have parameter XOF_LEN_W, default 8, the width of xof_words_i (used only when ASCON_XOF_EN is defined).
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start_i, input, 1, a one-cycle pulse that begins a new hash.
REQ-005 SHALL have port busy_o, output, 1, high from start until the final digest word is accepted.
REQ-006 SHALL have port msg_data_i, input, 64, a message block with byte 0 in bits [7:0].
REQ-007 SHALL have port msg_valid_i / msg_ready_o, in/out, 1 each, the message handshake.
REQ-008 SHALL have port msg_last_i, input, 1, marking the final, partial block.
REQ-009 SHALL have port msg_bytes_i, input, 3, the number of valid bytes (0..7) in the last block.
REQ-010 SHALL have port digest_o, output, 64, a digest word.
REQ-011 SHALL have port digest_valid_o / digest_ready_i, out/in, 1 each, the digest handshake.
REQ-012 SHALL have core-side ports core_start_perm_o, core_round_config_o, core_word_sel_o[2:0], core_data_o[63:0], core_write_en_o, core_xor_en_o (outputs) and core_data_i[63:0], core_ready_i (inputs), which drive the permutation core.

Function
REQ-013 SHALL have FSM states IDLE, INIT_WR, PERM_GO, PERM_WAIT, ABSORB, SQUEEZE.
- IDLE -> INIT_WR on start_i.
- start_i outside IDLE is ignored.
REQ-014 In INIT_WR, the block SHALL write 5 words over 5 cycles, with write_en=1 and xor_en=0:
- word 0 = ASCON_HASH256_IV (0x0000080100cc0002);
- words 1..4 = 0.
REQ-015 PERM_GO SHALL assert core_start_perm_o for exactly 1 cycle, with core_round_config_o=1 (12 rounds), then go to PERM_WAIT.
REQ-016 PERM_WAIT SHALL exit on core_ready_i=1; core_ready_i is low on the first PERM_WAIT cycle, giving a core turnaround of 14 cycles from the start pulse.
- Exit goes to ABSORB if the phase flag is absorb.
- Otherwise exit goes to SQUEEZE.
REQ-017 ABSORB SHALL assert msg_ready_o.
- On msg_valid_i&&msg_ready_o, XOR the padded block into word 0 in that same cycle (write_en=1, xor_en=1, word_sel=0), then go to PERM_GO.
REQ-018 Padding:
- Non-last blocks SHALL be absorbed unmodified, with msg_bytes_i ignored.
- Last block = (msg_data_i masked to the low 8*msg_bytes_i bits) | (64'h1 << 8*msg_bytes_i).
- Messages whose length is a multiple of 8 SHALL end with an empty last block (bytes=0 gives word 0x1).
REQ-019 After the last block's permutation, the phase flag SHALL switch to squeeze.
REQ-020 SQUEEZE SHALL hold core_word_sel_o=0 and register core_data_i into digest_o.
- digest_valid_o SHALL rise 1 cycle after SQUEEZE entry.
- digest_o/digest_valid_o SHALL hold stable until digest_ready_i.
REQ-021 On acceptance of words 0..2, the block SHALL go to PERM_GO.
REQ-022 On acceptance of word 3, the block SHALL go to IDLE and drop busy_o in the next cycle; no permutation follows the final word.
REQ-023 SHALL keep core_write_en_o=0 except in INIT_WR and on an ABSORB handshake cycle.
REQ-024 SHALL keep msg_ready_o=0 outside ABSORB.
REQ-025 SHALL keep digest_valid_o=0 outside SQUEEZE.
REQ-026 A 3-bit word counter and a 2-bit digest counter SHALL be used; neither wraps mid-hash, and both clear on IDLE exit.

Reset
REQ-027 rst SHALL force IDLE and clear the phase flag and counters.
- All outputs SHALL be 0, except core_round_config_o=1.
REQ-028 Reset mid-hash SHALL abandon the operation with no further core writes; the core shares rst.

Configuration
REQ-029 With ASCON_XOF_EN defined:
- inputs xof_mode_i[0] and xof_words_i[XOF_LEN_W-1:0] are sampled on start_i;
- xof_mode_i=1 selects ASCON_XOF128_IV (0x0000080000cc0003) and squeezes xof_words_i words;
- xof_words_i=0 is treated as 1.
REQ-030 Without ASCON_XOF_EN, these ports SHALL be absent and the block SHALL be fixed to Hash256 with 4 digest words.

Structure
REQ-031 SHALL place ASCON_HASH256_IV, ASCON_XOF128_IV and the hash_state_t enum in ascon_pkg, reusing ascon_word_t.
REQ-032 SHALL use combinational sub-module ascon_pad (data, bytes, last -> padded word).
REQ-033 SHALL NOT instantiate ascon_core; it is wired beside the core in the top level.

Verification
REQ-034 Reset SHALL be checked: rst mid-absorb -> next cycle busy_o=0, msg_ready_o=0, core_write_en_o=0.
REQ-035 Init SHALL be checked: start_i -> 5 writes (word 0 = 0x0000080100cc0002, words 1..4 = 0), then 1 start pulse with round_config=1.
REQ-036 Padding SHALL be checked: last block, bytes=3, data 0xFFFFFFFFFF636261 -> XOR operand 0x0000000001636261.
REQ-037 Empty message SHALL be checked: single last block, bytes=0 -> operand 0x1; 5 permutations total; 4 digest words matching the SP 800-232 Ascon-Hash256 KAT for the empty message.
REQ-038 Backpressure SHALL be checked: digest_ready_i low for 10 cycles -> digest_o stable, with no core start pulse in that interval.
REQ-039 XOF SHALL be checked (ASCON_XOF_EN defined): xof_mode_i=1, xof_words_i=6, empty message -> 6 words matching the XOF128 KAT, then busy_o=0.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared word type, initialisation vectors and controller states for the Ascon hash datapath.
package ascon_pkg;

  typedef logic [63:0] ascon_word_t;

  localparam ascon_word_t ASCON_HASH256_IV = 64'h0000_0801_00cc_0002;
  localparam ascon_word_t ASCON_XOF128_IV  = 64'h0000_0800_00cc_0003;

  localparam int unsigned ASCON_STATE_WORDS = 5;
  localparam int unsigned ASCON_HASH_WORDS  = 4;
  localparam logic        ASCON_ROUNDS_12   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    INIT_WR,
    PERM_GO,
    PERM_WAIT,
    ABSORB,
    SQUEEZE
  } hash_state_t;

endpackage

// File: rtl/ascon_pad.sv
// Sponge padding of one 64-bit rate block: keep the valid low bytes and append a 0x01 byte.
module ascon_pad (
  input  logic [63:0] data,
  input  logic [2:0]  bytes,
  input  logic        last,
  output logic [63:0] padded
);

  logic [5:0]  bit_pos;
  logic [63:0] pad_bit;

  assign bit_pos = {bytes, 3'b000};
  assign pad_bit = 64'h1 << bit_pos;

  // pad_bit - 1 is exactly the mask of the bytes below the padding byte.
  assign padded = last ? ((data & (pad_bit - 64'h1)) | pad_bit) : data;

endmodule

// File: rtl/ascon_hash_ctrl.sv
// Ascon-Hash256 sponge controller sequencing an external permutation core.
// Define ASCON_XOF_EN to add Ascon-XOF128 mode with a run-time digest length.
module ascon_hash_ctrl
  import ascon_pkg::*;
#(
  parameter int XOF_LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
`ifdef ASCON_XOF_EN
  input  logic                 xof_mode_i,
  input  logic [XOF_LEN_W-1:0] xof_words_i,
`endif
  output logic                 busy_o,
  input  logic [63:0]          msg_data_i,
  input  logic                 msg_valid_i,
  output logic                 msg_ready_o,
  input  logic                 msg_last_i,
  input  logic [2:0]           msg_bytes_i,
  output logic [63:0]          digest_o,
  output logic                 digest_valid_o,
  input  logic                 digest_ready_i,
  output logic                 core_start_perm_o,
  output logic                 core_round_config_o,
  output logic [2:0]           core_word_sel_o,
  output logic [63:0]          core_data_o,
  output logic                 core_write_en_o,
  output logic                 core_xor_en_o,
  input  logic [63:0]          core_data_i,
  input  logic                 core_ready_i
);

`ifdef ASCON_XOF_EN
  localparam int DIG_W = XOF_LEN_W;
`else
  localparam int DIG_W = 2;
`endif

  hash_state_t state_q, state_d;
  logic [2:0]       word_cnt_q;
  logic [DIG_W-1:0] dig_cnt_q;
  logic [DIG_W-1:0] dig_last;
  logic             squeeze_q;
  ascon_word_t      init_iv;
  ascon_word_t      padded;

  ascon_pad u_pad (
    .data   (msg_data_i),
    .bytes  (msg_bytes_i),
    .last   (msg_last_i),
    .padded (padded)
  );

`ifdef ASCON_XOF_EN
  logic             xof_q;
  logic [DIG_W-1:0] dig_last_q;

  // Mode and length are captured once so they stay constant for the whole hash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xof_q      <= 1'b0;
      dig_last_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      xof_q <= xof_mode_i;
      if (!xof_mode_i)               dig_last_q <= DIG_W'(ASCON_HASH_WORDS - 1);
      else if (xof_words_i == '0)    dig_last_q <= '0;
      else                           dig_last_q <= xof_words_i - 1'b1;
    end
  end

  assign init_iv  = xof_q ? ASCON_XOF128_IV : ASCON_HASH256_IV;
  assign dig_last = dig_last_q;
`else
  assign init_iv  = ASCON_HASH256_IV;
  assign dig_last = DIG_W'(ASCON_HASH_WORDS - 1);
`endif

  assign busy_o              = (state_q != IDLE);
  assign core_round_config_o = ASCON_ROUNDS_12;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d           = state_q;
    msg_ready_o       = 1'b0;
    core_start_perm_o = 1'b0;
    core_word_sel_o   = 3'd0;
    core_data_o       = '0;
    core_write_en_o   = 1'b0;
    core_xor_en_o     = 1'b0;
    case (state_q)
      IDLE: if (start_i) state_d = INIT_WR;
      INIT_WR: begin
        core_write_en_o = 1'b1;
        core_word_sel_o = word_cnt_q;
        core_data_o     = (word_cnt_q == 3'd0) ? init_iv : '0;
        if (word_cnt_q == 3'(ASCON_STATE_WORDS - 1)) state_d = PERM_GO;
      end
      PERM_GO: begin
        core_start_perm_o = 1'b1;
        state_d           = PERM_WAIT;
      end
      PERM_WAIT: if (core_ready_i) state_d = squeeze_q ? SQUEEZE : ABSORB;
      ABSORB: begin
        msg_ready_o = 1'b1;
        core_data_o = padded;
        if (msg_valid_i) begin
          core_write_en_o = 1'b1;
          core_xor_en_o   = 1'b1;
          state_d         = PERM_GO;
        end
      end
      SQUEEZE: begin
        if (digest_valid_o && digest_ready_i)
          state_d = (dig_cnt_q == dig_last) ? IDLE : PERM_GO;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      word_cnt_q     <= 3'd0;
      dig_cnt_q      <= '0;
      squeeze_q      <= 1'b0;
      digest_o       <= '0;
      digest_valid_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            word_cnt_q <= 3'd0;
            dig_cnt_q  <= '0;
            squeeze_q  <= 1'b0;
          end
        end
        INIT_WR: word_cnt_q <= word_cnt_q + 3'd1;
        // The permutation following the last block is the one that leads to squeezing.
        ABSORB: if (msg_valid_i && msg_last_i) squeeze_q <= 1'b1;
        SQUEEZE: begin
          if (!digest_valid_o) begin
            digest_o       <= core_data_i;
            digest_valid_o <= 1'b1;
          end else if (digest_ready_i) begin
            digest_valid_o <= 1'b0;
            if (dig_cnt_q != dig_last) dig_cnt_q <= dig_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_hash_ctrl.sv
// Bench for ascon_hash_ctrl: vector table, write/digest scoreboards and a behavioural Ascon core.
module tb_ascon_hash_ctrl;

  typedef logic [4:0][63:0] st_t;
  typedef struct { logic [63:0] data; logic last; logic [2:0] bytes; logic [63:0] exp; } vec_t;
  typedef struct { logic [2:0] sel; logic xr; logic [63:0] data; } wr_t;

  localparam logic [63:0] HASH_IV = 64'h0000080100cc0002;
  localparam logic [63:0] XOF_IV  = 64'h0000080000cc0003;

  logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0;
  logic        busy_o, msg_valid_i = 1'b0, msg_ready_o, msg_last_i = 1'b0;
  logic [63:0] msg_data_i = '0;
  logic [2:0]  msg_bytes_i = '0;
  logic [63:0] digest_o;
  logic        digest_valid_o, digest_ready_i = 1'b0;
  logic        core_start_perm_o, core_round_config_o, core_write_en_o, core_xor_en_o, core_ready_i;
  logic [2:0]  core_word_sel_o;
  logic [63:0] core_data_o, core_data_i;
`ifdef ASCON_XOF_EN
  logic        xof_mode_i = 1'b0;
  logic [7:0]  xof_words_i = '0;
`endif

  int   n_tests = 0, n_fail = 0, n_starts = 0;
  wr_t  wq[$];
  logic [63:0] dq[$];
  st_t  sw, core_st;
  int   core_busy;
  vec_t vecs[8];

  ascon_hash_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i),
`ifdef ASCON_XOF_EN
    .xof_mode_i(xof_mode_i), .xof_words_i(xof_words_i),
`endif
    .busy_o(busy_o), .msg_data_i(msg_data_i), .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
    .msg_last_i(msg_last_i), .msg_bytes_i(msg_bytes_i), .digest_o(digest_o),
    .digest_valid_o(digest_valid_o), .digest_ready_i(digest_ready_i),
    .core_start_perm_o(core_start_perm_o), .core_round_config_o(core_round_config_o),
    .core_word_sel_o(core_word_sel_o), .core_data_o(core_data_o), .core_write_en_o(core_write_en_o),
    .core_xor_en_o(core_xor_en_o), .core_data_i(core_data_i), .core_ready_i(core_ready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic st_t p12(input st_t s_in);
    st_t s, t;
    s = s_in;
    for (int r = 0; r < 12; r++) begin
      s[2] = s[2] ^ {56'h0, 4'(15 - r), 4'(r)};
      s[0] = s[0] ^ s[4];
      s[4] = s[4] ^ s[3];
      s[2] = s[2] ^ s[1];
      for (int i = 0; i < 5; i++) t[i] = ~s[i] & s[(i + 1) % 5];
      for (int i = 0; i < 5; i++) s[i] = s[i] ^ t[(i + 1) % 5];
      s[1] = s[1] ^ s[0];
      s[0] = s[0] ^ s[4];
      s[3] = s[3] ^ s[2];
      s[2] = ~s[2];
      s[0] = s[0] ^ ror(s[0], 19) ^ ror(s[0], 28);
      s[1] = s[1] ^ ror(s[1], 61) ^ ror(s[1], 39);
      s[2] = s[2] ^ ror(s[2], 1)  ^ ror(s[2], 6);
      s[3] = s[3] ^ ror(s[3], 10) ^ ror(s[3], 17);
      s[4] = s[4] ^ ror(s[4], 7)  ^ ror(s[4], 41);
    end
    return s;
  endfunction

  // Behavioural permutation core: ready drops for 13 cycles after a start pulse.
  always_comb begin
    core_data_i = 64'h0;
    if (core_word_sel_o < 3'd5) core_data_i = core_st[int'(core_word_sel_o)];
  end
  assign core_ready_i = (core_busy == 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_st   <= '0;
      core_busy <= 0;
    end else begin
      if (core_write_en_o && core_word_sel_o < 3'd5)
        core_st[int'(core_word_sel_o)] <= core_xor_en_o ? (core_st[int'(core_word_sel_o)] ^ core_data_o)
                                                        : core_data_o;
      if (core_start_perm_o) begin
        core_st   <= p12(core_st);
        core_busy <= 13;
      end else if (core_busy != 0) begin
        core_busy <= core_busy - 1;
      end
    end
  end

  always @(posedge clk) if (core_start_perm_o) n_starts <= n_starts + 1;

  wr_t         mon_e;
  logic [63:0] mon_d;
  logic        prev_start = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (core_write_en_o) begin
        if (wq.size() == 0) check("unexpected_write", 64'(core_write_en_o), 64'h0);
        else begin
          mon_e = wq.pop_front();
          check("wr_data", core_data_o, mon_e.data);
          check("wr_ctrl", {60'h0, core_word_sel_o, core_xor_en_o}, {60'h0, mon_e.sel, mon_e.xr});
        end
      end
      if (core_start_perm_o) begin
        check("round_cfg", 64'(core_round_config_o), 64'h1);
        check("start_one_cycle", 64'(prev_start), 64'h0);
      end
      if (digest_valid_o && digest_ready_i) begin
        if (dq.size() == 0) check("unexpected_digest", 64'(digest_valid_o), 64'h0);
        else begin
          mon_d = dq.pop_front();
          check("digest", digest_o, mon_d);
        end
      end
    end
    prev_start = core_start_perm_o;
  end

  task automatic do_start(input logic [63:0] iv);
    @(posedge clk); #1;
    start_i = 1'b1;
    for (int i = 0; i < 5; i++) wq.push_back('{3'(i), 1'b0, (i == 0) ? iv : 64'h0});
    sw    = '0;
    sw[0] = iv;
    sw    = p12(sw);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send_block(input vec_t v);
    @(posedge clk); #1;
    msg_data_i  = v.data;
    msg_last_i  = v.last;
    msg_bytes_i = v.bytes;
    msg_valid_i = 1'b1;
    wq.push_back('{3'd0, 1'b1, v.exp});
    for (int n = 0; n < 200 && !msg_ready_o; n++) @(negedge clk);
    check("absorb_ready", 64'(msg_ready_o), 64'h1);
    @(posedge clk); #1;
    msg_valid_i = 1'b0;
    sw[0] = sw[0] ^ v.exp;
    sw    = p12(sw);
  endtask

  task automatic push_digest(input int n);
    for (int k = 0; k < n; k++) begin
      dq.push_back(sw[0]);
      if (k < n - 1) sw = p12(sw);
    end
  endtask

  task automatic drain(input int budget);
    digest_ready_i = 1'b1;
    for (int n = 0; n < budget && busy_o; n++) @(negedge clk);
    check("hash_done", 64'(busy_o), 64'h0);
    check("digest_q_empty", 64'(dq.size()), 64'h0);
    check("write_q_empty", 64'(wq.size()), 64'h0);
    @(posedge clk); #1;
    digest_ready_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts0;
    vecs[0] = '{64'h0123456789ABCDEF, 1'b0, 3'd3, 64'h0123456789ABCDEF};
    vecs[1] = '{64'hFFFFFFFFFF636261, 1'b1, 3'd3, 64'h0000000001636261};
    vecs[2] = '{64'hDEADBEEFCAFEF00D, 1'b1, 3'd0, 64'h0000000000000001};
    vecs[3] = '{64'hDEADBEEFCAFEF00D, 1'b1, 3'd7, 64'h01ADBEEFCAFEF00D};
    vecs[4] = '{64'h1122334455667788, 1'b0, 3'd7, 64'h1122334455667788};
    vecs[5] = '{64'h8877665544332211, 1'b0, 3'd0, 64'h8877665544332211};
    vecs[6] = '{64'hA5A5A5A5A5A5A5A5, 1'b1, 3'd1, 64'h00000000000001A5};
    vecs[7] = '{64'h0F0E0D0C0B0A0908, 1'b1, 3'd5, 64'h0000010C0B0A0908};

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_msg_ready", 64'(msg_ready_o), 64'h0);
    check("rst_digest_valid", 64'(digest_valid_o), 64'h0);
    check("rst_digest", digest_o, 64'h0);
    check("rst_start", 64'(core_start_perm_o), 64'h0);
    check("rst_write_en", 64'(core_write_en_o), 64'h0);
    check("rst_round_cfg", 64'(core_round_config_o), 64'h1);
    check("rst_core_data", core_data_o, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table of blocks; a last block closes a message and its digest is drained.
    begin
      bit first = 1'b1;
      foreach (vecs[i]) begin
        if (first) do_start(HASH_IV);
        send_block(vecs[i]);
        first = vecs[i].last;
        if (vecs[i].last) begin
          push_digest(4);
          drain(1000);
        end
      end
    end

    // Empty message against the Ascon-Hash256 known answer.
    starts0 = n_starts;
    do_start(HASH_IV);
    send_block('{64'hFFFFFFFFFFFFFFFF, 1'b1, 3'd0, 64'h0000000000000001});
    dq.push_back(64'h986B2F0F85E53B0B);
    dq.push_back(64'h649BA8DE8F9FF2CA);
    dq.push_back(64'h838F9B24AA70FAA1);
    dq.push_back(64'hB2924D30AA3BD59B);
    drain(1000);
    check("empty_perm_count", 64'(n_starts - starts0), 64'd5);

    // Digest backpressure, with a start pulse that must be ignored while busy.
    do_start(HASH_IV);
    send_block('{64'h123456789ABCDEF0, 1'b1, 3'd2, 64'h000000000001DEF0});
    push_digest(4);
    digest_ready_i = 1'b0;
    for (int n = 0; n < 100 && !digest_valid_o; n++) @(negedge clk);
    check("bp_valid_rise", 64'(digest_valid_o), 64'h1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (n == 3) start_i = 1'b1;
      if (n == 4) start_i = 1'b0;
      check("bp_digest_hold", digest_o, dq[0]);
      check("bp_valid_hold", 64'(digest_valid_o), 64'h1);
      check("bp_no_start", 64'(core_start_perm_o), 64'h0);
    end
    start_i = 1'b0;
    drain(1000);

`ifdef ASCON_XOF_EN
    // XOF128 with six words: four against the known answer, the rest from the model.
    xof_mode_i  = 1'b1;
    xof_words_i = 8'd6;
    do_start(XOF_IV);
    send_block('{64'h0, 1'b1, 3'd0, 64'h0000000000000001});
    dq.push_back(64'h398BF564615E3D47);
    dq.push_back(64'h2EE48ADBAC4AD8DF);
    dq.push_back(64'hE08E3833ED1FD9C2);
    dq.push_back(64'hC6953299B3D960D9);
    repeat (4) sw = p12(sw);
    push_digest(2);
    drain(2000);
    xof_words_i = 8'd0;
    do_start(XOF_IV);
    send_block('{64'h0, 1'b1, 3'd0, 64'h0000000000000001});
    push_digest(1);
    drain(1000);
    xof_mode_i = 1'b0;
`endif

    // Reset in the middle of absorbing abandons the hash.
    do_start(HASH_IV);
    for (int n = 0; n < 100 && !msg_ready_o; n++) @(negedge clk);
    check("rst_mid_absorb_reach", 64'(msg_ready_o), 64'h1);
    @(posedge clk); #1;
    msg_valid_i = 1'b1;
    msg_last_i  = 1'b1;
    msg_bytes_i = 3'd0;
    rst         = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy_o), 64'h0);
    check("rst_mid_msg_ready", 64'(msg_ready_o), 64'h0);
    check("rst_mid_write_en", 64'(core_write_en_o), 64'h0);
    wq.delete();
    dq.delete();
    @(posedge clk); #1;
    rst         = 1'b0;
    msg_valid_i = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("rst_after_write_en", 64'(core_write_en_o), 64'h0);
    end
    check("rst_after_busy", 64'(busy_o), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
